// File: rtl/dvi_serialiser_sc.sv
// Multi-channel word serialiser for the TMDS/DVI path: FIFO-fed shift registers emitting W_OUT bits/channel/cycle.
// Optional registered complement output dout_n enabled by DVI_SERIALISER_SC_NEG_OUTPUT_EN.
module dvi_serialiser_sc #(
  parameter int              W_IN      = 10,
  parameter int              W_OUT     = 2,
  parameter int              N_CHAN    = 3,
  parameter int              DEPTH     = 4,
  parameter logic [W_IN-1:0] IDLE_WORD = 10'h354
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CHAN*W_IN-1:0]   din,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [N_CHAN*W_OUT-1:0]  dout,
  output logic [N_CHAN*W_OUT-1:0]  dout_n,
  output logic                     word_start,
  output logic                     underflow,
  input  logic                     underflow_clr
);

  localparam int RATIO = W_IN / W_OUT;
  localparam int CTR_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(RATIO - 1);

  logic [CTR_W-1:0]             ctr;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [N_CHAN*W_IN-1:0]       mem [DEPTH];
  logic [N_CHAN*W_IN-1:0]       head;
  logic [N_CHAN-1:0][W_IN-1:0]  sreg, sreg_nxt;
  logic                         full, empty, push, pop, load_edge;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign din_ready  = !full;
  assign push       = din_valid && !full;
  assign load_edge  = (ctr == CTR_MAX);
  assign pop        = load_edge && !empty;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign word_start = (ctr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= '0;
    end else if (load_edge) begin
      ctr <= '0;
    end else begin
      ctr <= ctr + CTR_W'(1);
    end
  end

  // Reset only clears the pointers; stale storage contents are unreachable afterwards.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // A load against an empty FIFO takes the idle word even if a write lands on the same edge.
  always_comb begin
    sreg_nxt = sreg;
    for (int c = 0; c < N_CHAN; c++) begin
      if (load_edge) begin
        sreg_nxt[c] = empty ? IDLE_WORD : head[c*W_IN +: W_IN];
      end else begin
        sreg_nxt[c] = sreg[c] >> W_OUT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= {N_CHAN{IDLE_WORD}};
    end else begin
      sreg <= sreg_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (load_edge && empty) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  for (genvar c = 0; c < N_CHAN; c++) begin : g_dout
    assign dout[c*W_OUT +: W_OUT] = sreg[c][W_OUT-1:0];
  end

`ifdef DVI_SERIALISER_SC_NEG_OUTPUT_EN
  logic [N_CHAN*W_OUT-1:0] dout_nxt, dout_n_q;

  always_comb begin
    dout_nxt = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      dout_nxt[c*W_OUT +: W_OUT] = sreg_nxt[c][W_OUT-1:0];
    end
  end

  // Separate flop so the complement leaves on the same edge as dout, with no inverter skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_n_q <= ~{N_CHAN{IDLE_WORD[W_OUT-1:0]}};
    end else begin
      dout_n_q <= ~dout_nxt;
    end
  end

  assign dout_n = dout_n_q;
`else
  assign dout_n = '0;
`endif

endmodule

// File: tb/tb_dvi_serialiser_sc.sv
// Self-checking bench for dvi_serialiser_sc (defaults: W_IN=10, W_OUT=2, N_CHAN=3, DEPTH=4).
// Table-driven streaming vectors plus hand sequences for burst, same-edge write and mid-word reset.
module tb_dvi_serialiser_sc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [5:0]  dout;
  logic [5:0]  dout_n;
  logic        word_start;
  logic        underflow;
  logic        underflow_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [29:0] IDLE3 = {3{10'h354}};
  localparam logic [29:0] WX = {10'h2AA, 10'h000, 10'h3FF};
  localparam logic [29:0] WY = {10'h155, 10'h3FF, 10'h000};
  localparam logic [5:0]  DX = 6'b10_00_11;
  localparam logic [5:0]  DY = 6'b01_11_00;
  localparam logic [5:0]  I0 = 6'b00_00_00;
  localparam logic [5:0]  I1 = 6'b01_01_01;
  localparam logic [5:0]  I4 = 6'b11_11_11;

  typedef struct {
    logic        valid;
    logic [29:0] din;
    logic        clr;
    logic [5:0]  exp_dout;
    logic        exp_ws;
    logic        exp_uf;
  } vec_t;

  vec_t vecs[$];

  dvi_serialiser_sc dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_n(dout_n), .word_start(word_start), .underflow(underflow),
    .underflow_clr(underflow_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_dout_n(input string name);
`ifdef DVI_SERIALISER_SC_NEG_OUTPUT_EN
    check_output(name, 32'(dout_n), 32'(~dout));
`else
    check_output(name, 32'(dout_n), 32'h0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    underflow_clr = 1'b0;
    din = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic v, input logic [29:0] d, input logic c,
                     input logic [5:0] o, input logic ws, input logic uf);
    vec_t r;
    r.valid = v; r.din = d; r.clr = c; r.exp_dout = o; r.exp_ws = ws; r.exp_uf = uf;
    vecs.push_back(r);
  endtask

  task automatic apply_stimulus(input vec_t r);
    din = r.din;
    din_valid = r.valid;
    underflow_clr = r.clr;
    step();
  endtask

  function automatic logic [29:0] make_word(input int k);
    logic [29:0] w;
    for (int c = 0; c < 3; c++) w[c*10 +: 10] = 10'((k << 5) | (c << 1) | 1);
    return w;
  endfunction

  initial begin
    logic [29:0] got_words[$];

    // Idle stream, then one word per period alternating WX/WY, then underflow/clear interplay.
    add(0, '0, 0, I1, 0, 0); add(0, '0, 0, I1, 0, 0); add(0, '0, 0, I1, 0, 0);
    add(0, '0, 0, I4, 0, 0); add(0, '0, 0, I0, 1, 1);
    add(1, WX, 1, I1, 0, 0); add(1, WY, 0, I1, 0, 0); add(0, '0, 0, I1, 0, 0);
    add(0, '0, 0, I4, 0, 0); add(0, '0, 0, DX, 1, 0);
    add(1, WX, 0, DX, 0, 0);
    for (int i = 0; i < 3; i++) add(0, '0, 0, DX, 0, 0);
    add(0, '0, 0, DY, 1, 0);
    add(1, WY, 0, DY, 0, 0);
    for (int i = 0; i < 3; i++) add(0, '0, 0, DY, 0, 0);
    add(0, '0, 0, DX, 1, 0);
    for (int i = 0; i < 4; i++) add(0, '0, 0, DX, 0, 0);
    add(0, '0, 0, DY, 1, 0);
    for (int i = 0; i < 4; i++) add(0, '0, 0, DY, 0, 0);
    add(0, '0, 1, I0, 1, 1);
    add(1, WX, 1, I1, 0, 0);
    add(0, '0, 0, I1, 0, 0); add(0, '0, 0, I1, 0, 0); add(0, '0, 0, I4, 0, 0);
    add(0, '0, 0, DX, 1, 0);

    do_reset();
    check_output("reset_dout", 32'(dout), 32'(I0));
    check_output("reset_word_start", 32'(word_start), 32'h1);
    check_output("reset_din_ready", 32'(din_ready), 32'h1);
    check_output("reset_underflow", 32'(underflow), 32'h0);
    check_dout_n("reset_dout_n");

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
      check_output($sformatf("vec%0d_ws", i), 32'(word_start), 32'(vecs[i].exp_ws));
      check_output($sformatf("vec%0d_ready", i), 32'(din_ready), 32'h1);
      check_output($sformatf("vec%0d_uf", i), 32'(underflow), 32'(vecs[i].exp_uf));
      check_dout_n($sformatf("vec%0d_dout_n", i));
    end
    din_valid = 1'b0;
    underflow_clr = 1'b0;

    // Burst of six words with valid held: the FIFO must fill and back-pressure without loss.
    do_reset();
    fork
      begin : burst_drv
        int  k;
        int  cyc;
        bit  acc;
        bit  saw_low;
        k = 0; cyc = 0; saw_low = 0;
        while (k < 6 && cyc < 100) begin
          din = make_word(k);
          din_valid = 1'b1;
          acc = din_ready;
          if (!din_ready) saw_low = 1;
          step();
          if (acc) k++;
          cyc++;
        end
        din_valid = 1'b0;
        check_output("burst_accepted", 32'(k), 32'd6);
        check_output("burst_ready_low", 32'(saw_low), 32'h1);
      end
      begin : burst_mon
        logic [29:0] acc_w;
        int          ph;
        bit          started;
        acc_w = '0; ph = 0; started = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
          step();
          if (word_start) begin
            started = 1;
            ph = 0;
          end
          if (started && ph < 5) begin
            for (int c = 0; c < 3; c++) acc_w[c*10 + 2*ph +: 2] = dout[c*2 +: 2];
            if (ph == 4 && acc_w != IDLE3) got_words.push_back(acc_w);
            ph++;
          end
        end
      end
    join
    check_output("burst_count", 32'(got_words.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_words.size())
        check_output($sformatf("burst_word%0d", i), 32'(got_words[i]), 32'(make_word(i)));
    end

    // Write landing on the load edge with an empty FIFO waits a full word period.
    do_reset();
    repeat (4) step();
    din = {10'h2AA, 10'h155, 10'h3FF};
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check_output("same_edge_idle_dout", 32'(dout), 32'(I0));
    check_output("same_edge_uf", 32'(underflow), 32'h1);
    check_output("same_edge_ws", 32'(word_start), 32'h1);
    step();
    check_output("same_edge_idle_bit1", 32'(dout), 32'(I1));
    repeat (3) step();
    check_output("same_edge_idle_last", 32'(dout), 32'(I4));
    step();
    check_output("same_edge_word_dout", 32'(dout), 32'b10_01_11);
    check_output("same_edge_word_ws", 32'(word_start), 32'h1);

    // Asynchronous reset mid-word with three words queued: all of them must be discarded.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      din = (k % 2 == 0) ? WX : WY;
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
    repeat (3) step();
    check_output("pre_reset_dout", 32'(dout), 32'(DX));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_dout", 32'(dout), 32'(I0));
    check_output("async_reset_ws", 32'(word_start), 32'h1);
    check_output("async_reset_ready", 32'(din_ready), 32'h1);
    check_output("async_reset_uf", 32'(underflow), 32'h0);
    check_dout_n("async_reset_dout_n");
    step();
    check_output("held_reset_dout", 32'(dout), 32'(I0));
    rst_n = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      logic [5:0] exp;
      step();
      case (e % 5)
        0:       exp = I0;
        4:       exp = I4;
        default: exp = I1;
      endcase
      check_output($sformatf("post_reset_e%0d", e), 32'(dout), 32'(exp));
      check_dout_n($sformatf("post_reset_dout_n_e%0d", e));
      if (e == 5) check_output("post_reset_uf", 32'(underflow), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
